// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_pkg: shared register-file widths and writeback controller state type
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic {INIT, RUN} wb_state_t;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant starting the search at ptr
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) gnt = N'(1) << ((int'(ptr) + k) % N);
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file init sweep plus round-robin shared write port
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter bit INIT_EN = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     init_done
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NUM_REGS);
  localparam logic [CW-1:0] LAST = CW'(NUM_REGS - 1);
  wb_state_t state;
  logic [CW-1:0] init_cnt;
  logic [PW-1:0] rr_ptr, sel;
  logic [NREQ-1:0] gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic xfer, do_write;
  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (.req(req_valid), .ptr(rr_ptr), .gnt(gnt));
  assign req_ready = (reset_n && state == RUN) ? gnt : '0;
  assign xfer = |req_ready;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel = PW'(i);
    end
  end
  assign sel_addr = req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(sel)*DATA_W +: DATA_W];
  assign do_write = xfer && sel_addr != '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT_EN ? INIT : RUN;
      init_done <= !INIT_EN;
      init_cnt <= '0;
      rr_ptr <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (state == INIT) begin
      wr_en <= 1'b1;
      wr_addr <= ADDR_W'(init_cnt);
      wr_data <= INIT_VALUE;
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST) begin
        state <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (xfer) rr_ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: randomized check of regfile_wb_ctrl against a behavioural model
module tb_regfile_wb_ctrl;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic reset_n;
  logic [NREQ-1:0] rv;
  logic [4:0] a [NREQ];
  logic [31:0] d [NREQ];
  logic [NREQ-1:0] rdy;
  logic en, done;
  logic [4:0] waddr;
  logic [31:0] wdata;
  logic [NREQ-1:0] rv0, rdy0;
  logic [9:0] addr0;
  logic [63:0] data0;
  logic en0, done0;
  logic [4:0] waddr0;
  logic [31:0] wdata0;
  int n_checks = 0, n_errors = 0;
  int m_ptr, m_cnt, last_g;
  bit m_done, m_en;
  logic [4:0] m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREQ(NREQ), .INIT_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(rv), .req_addr({a[1], a[0]}),
    .req_data({d[1], d[0]}), .req_ready(rdy), .wr_en(en), .wr_addr(waddr),
    .wr_data(wdata), .init_done(done)
  );

  regfile_wb_ctrl #(.NREQ(NREQ), .INIT_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(rv0), .req_addr(addr0),
    .req_data(data0), .req_ready(rdy0), .wr_en(en0), .wr_addr(waddr0),
    .wr_data(wdata0), .init_done(done0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_done = 0; m_en = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic check_outs();
    check("wr_en", en, m_en);
    check("wr_addr", waddr, m_addr);
    check("wr_data", wdata, m_data);
    check("init_done", done, m_done);
  endtask

  task automatic cycle();
    logic [NREQ-1:0] exp_g;
    int g;
    #1;
    exp_g = '0;
    g = -1;
    if (m_done) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && rv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    check("req_ready", rdy, exp_g);
    @(posedge clk);
    if (!m_done) begin
      m_en = 1; m_addr = 5'(m_cnt); m_data = '0;
      m_cnt++;
      if (m_cnt == 32) m_done = 1;
    end else begin
      m_en = (g >= 0) && (a[g] != 0);
      if (m_en) begin
        m_addr = a[g];
        m_data = d[g];
      end
      if (g >= 0) m_ptr = (g + 1) % NREQ;
    end
    last_g = g;
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    reset_n = 1'b0;
    rv = 2'b11; a[0] = 5'd3; a[1] = 5'd7; d[0] = 32'hA0A0_0003; d[1] = 32'hB0B0_0007;
    rv0 = 2'b01; addr0 = {5'd0, 5'd5}; data0 = {32'd0, 32'hDEAD_BEEF};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outs();
    check("reset_ready", rdy, 0);
    check("reset_ready0", rdy0, 0);
    check("reset_done0", done0, 1);
    check("reset_en0", en0, 0);
    reset_n = 1'b1;
    #1;
    check("d0_ready", rdy0, 2'b01);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i == 0) begin
        check("d0_wr_en", en0, 1);
        check("d0_wr_addr", waddr0, 5);
        check("d0_wr_data", wdata0, 32'hDEAD_BEEF);
        rv0 = '0;
      end
      if (i == 1) check("d0_idle", en0, 0);
    end
    rv = '0;
    cycle();
    rv = 2'b10; a[1] = 5'd0; d[1] = 32'h1234;
    cycle();
    rv = 2'b01; a[0] = 5'd2; d[0] = 32'h5555_0002;
    cycle();
    rv = '0;
    cycle();
    for (int i = 0; i < 300; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!rv[r] && $urandom_range(1, 0) == 1) begin
          rv[r] = 1'b1;
          a[r] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
          d[r] = $urandom;
        end
      end
      cycle();
      if (last_g >= 0) rv[last_g] = 1'b0;
    end
    rv = 2'b11;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    check("rst_ready", rdy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    while (m_cnt < 17) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    check("mid_rst_ready", rdy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 36; i++) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
